// File: rtl/top_data_sm.sv
// Keypad command interpreter: parses "motor SPACE direction angle terminator"
// and drives the selected stepper's full-step phase pattern, one step per degree.
module top_data_sm #(
    parameter int STEP_DIV  = 50000,
    parameter int MAX_ANGLE = 360
) (
    input  logic       in_Clk,
    input  logic       in_Rst,
    input  logic       i_ena,
    input  logic [3:0] i_data_dec,
    output logic       out_led_ini,
    output logic [3:0] out_Motor_PWM_A,
    output logic [3:0] out_Motor_PWM_B,
    output logic [3:0] out_Motor_PWM_C,
    output logic [3:0] out_Motor_PWM_D
);

    localparam int              DIV_W     = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [9:0]      ANGLE_MAX = 10'(MAX_ANGLE);

    localparam logic [3:0] K_SPACE = 4'd10;
    localparam logic [3:0] K_ENTER = 4'd11;
    localparam logic [3:0] K_FWD   = 4'd12;
    localparam logic [3:0] K_BWD   = 4'd13;

    typedef enum logic [2:0] {IDLE, MOTOR, SEP, DIR, ANGLE, RUN} state_t;

    state_t           state_q, state_d;
    logic             ena_q;
    logic [2:0]       motor_q, motor_d;
    logic             dir_q, dir_d;          // 1 = backward
    logic [9:0]       angle_q, angle_d;
    logic [1:0]       count_q, count_d;
    logic [9:0]       steps_q, steps_d;
    logic [1:0]       phase_q, phase_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             led_d;
    logic [3:0]       pwm_a_d, pwm_b_d, pwm_c_d, pwm_d_d;
    logic [3:0]       pattern;

    logic key_stb;
    logic is_digit;
    assign key_stb  = i_ena & ~ena_q;
    assign is_digit = (i_data_dec <= 4'd9);

    // NOTE: reset is synchronous, so it only lands on a clock edge; every
    // register (including all outputs) returns to its idle value together.
    always_ff @(posedge in_Clk) begin
        if (in_Rst) begin
            state_q         <= IDLE;
            ena_q           <= 1'b0;
            motor_q         <= '0;
            dir_q           <= 1'b0;
            angle_q         <= '0;
            count_q         <= '0;
            steps_q         <= '0;
            phase_q         <= '0;
            div_q           <= '0;
            out_led_ini     <= 1'b1;
            out_Motor_PWM_A <= '0;
            out_Motor_PWM_B <= '0;
            out_Motor_PWM_C <= '0;
            out_Motor_PWM_D <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q         <= state_d;
            ena_q           <= i_ena;
            motor_q         <= motor_d;
            dir_q           <= dir_d;
            angle_q         <= angle_d;
            count_q         <= count_d;
            steps_q         <= steps_d;
            phase_q         <= phase_d;
            div_q           <= div_d;
            out_led_ini     <= led_d;
            out_Motor_PWM_A <= pwm_a_d;
            out_Motor_PWM_B <= pwm_b_d;
            out_Motor_PWM_C <= pwm_c_d;
            out_Motor_PWM_D <= pwm_d_d;
        end
    end

    always_comb begin
        logic clear;
        // NOTE: every combinationally assigned signal gets a default first so
        // no path through the case statement can infer a latch.
        clear   = 1'b0;
        state_d = state_q;
        motor_d = motor_q;
        dir_d   = dir_q;
        angle_d = angle_q;
        count_d = count_q;
        steps_d = steps_q;
        phase_d = phase_q;
        div_d   = div_q;

        case (state_q)
            IDLE: begin
                if (key_stb && i_data_dec >= 4'd1 && i_data_dec <= 4'd4) begin
                    motor_d = i_data_dec[2:0];
                    state_d = MOTOR;
                end
            end
            MOTOR: begin
                if (key_stb) begin
                    if (i_data_dec == K_SPACE) state_d = SEP;
                    else                       clear   = 1'b1;
                end
            end
            SEP: begin
                if (key_stb) begin
                    if (i_data_dec == K_FWD || i_data_dec == K_BWD) begin
                        dir_d   = (i_data_dec == K_BWD);
                        state_d = DIR;
                    end else begin
                        clear = 1'b1;
                    end
                end
            end
            DIR: begin
                if (key_stb) begin
                    if (is_digit) begin
                        angle_d = {6'd0, i_data_dec};
                        count_d = 2'd1;
                        state_d = ANGLE;
                    end else begin
                        clear = 1'b1;
                    end
                end
            end
            ANGLE: begin
                if (key_stb) begin
                    if (is_digit) begin
                        if (count_q < 2'd3) begin
                            angle_d = angle_q * 10'd10 + {6'd0, i_data_dec};
                            count_d = count_q + 2'd1;
                        end else begin
                            clear = 1'b1;
                        end
                    end else if (i_data_dec == K_ENTER || i_data_dec == K_SPACE) begin
                        // Zero or oversize angles both end in IDLE with fields cleared.
                        if (angle_q > ANGLE_MAX || angle_q == 10'd0) begin
                            clear = 1'b1;
                        end else begin
                            steps_d = angle_q;
                            phase_d = 2'd0;
                            div_d   = '0;
                            state_d = RUN;
                        end
                    end else begin
                        clear = 1'b1;
                    end
                end
            end
            RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    phase_d = phase_q + 2'd1;
                    steps_d = steps_q - 10'd1;
                    if (steps_q == 10'd1) clear = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: clear = 1'b1;
        endcase

        if (clear) begin
            state_d = IDLE;
            motor_d = '0;
            dir_d   = 1'b0;
            angle_d = '0;
            count_d = '0;
        end
    end

    // Outputs are computed from the next state so they change on the same edge.
    always_comb begin
        pattern = dir_d ? (4'b0001 << phase_d) : (4'b1000 >> phase_d);
        led_d   = (state_d == IDLE);
        pwm_a_d = '0;
        pwm_b_d = '0;
        pwm_c_d = '0;
        pwm_d_d = '0;
        if (state_d == RUN) begin
            case (motor_d)
                3'd1:    pwm_a_d = pattern;
                3'd2:    pwm_b_d = pattern;
                3'd3:    pwm_c_d = pattern;
                3'd4:    pwm_d_d = pattern;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_top_data_sm.sv
// Directed bench for top_data_sm: command parsing, step sequences, aborts, reset.
module tb_top_data_sm;

    localparam int STEP_DIV = 4;

    localparam logic [3:0] K_SPACE = 4'd10;
    localparam logic [3:0] K_ENTER = 4'd11;
    localparam logic [3:0] K_FWD   = 4'd12;
    localparam logic [3:0] K_BWD   = 4'd13;
    localparam logic [3:0] K_INV   = 4'd14;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] data;
    logic       led;
    logic [3:0] pwm_a, pwm_b, pwm_c, pwm_d;
    logic [15:0] pwm_all;

    int n_cmp = 0;
    int n_bad = 0;

    top_data_sm #(.STEP_DIV(STEP_DIV), .MAX_ANGLE(360)) dut (
        .in_Clk          (clk),
        .in_Rst          (rst),
        .i_ena           (ena),
        .i_data_dec      (data),
        .out_led_ini     (led),
        .out_Motor_PWM_A (pwm_a),
        .out_Motor_PWM_B (pwm_b),
        .out_Motor_PWM_C (pwm_c),
        .out_Motor_PWM_D (pwm_d)
    );

    assign pwm_all = {pwm_a, pwm_b, pwm_c, pwm_d};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] pat(input logic back, input int ph);
        logic [3:0] p;
        case (ph % 4)
            0:       p = back ? 4'b0001 : 4'b1000;
            1:       p = back ? 4'b0010 : 4'b0100;
            2:       p = back ? 4'b0100 : 4'b0010;
            default: p = back ? 4'b1000 : 4'b0001;
        endcase
        return p;
    endfunction

    function automatic logic [15:0] place(input int motor, input logic [3:0] p);
        case (motor)
            1:       return {p, 12'h000};
            2:       return {4'h0, p, 8'h00};
            3:       return {8'h00, p, 4'h0};
            4:       return {12'h000, p};
            default: return 16'h0000;
        endcase
    endfunction

    // One cycle high, one cycle low; returns at the negedge after the accepting edge.
    task automatic send_key(input logic [3:0] code);
        @(negedge clk);
        data = code;
        ena  = 1'b1;
        @(negedge clk);
        ena  = 1'b0;
    endtask

    task automatic run_check(input int motor, input logic back, input int angle,
                             input int limit, input logic noise);
        for (int i = 0; i < limit; i++) begin
            check("run_pwm", pwm_all, place(motor, pat(back, i / STEP_DIV)));
            check("run_led", led, 1'b0);
            if (noise) begin
                data = 4'd1;
                ena  = (i % 2 == 1);
            end
            @(negedge clk);
        end
        if (limit == angle * STEP_DIV) begin
            check("end_pwm", pwm_all, 16'h0000);
            check("end_led", led, 1'b1);
            if (noise) begin
                @(negedge clk);
                check("end_key_ignored", led, 1'b1);
                ena = 1'b0;
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        ena  = 1'b1;
        data = 4'd2;
        @(negedge clk);
        check("rst_led_0", led, 1'b1);
        check("rst_pwm_0", pwm_all, 16'h0000);
        @(negedge clk);
        check("rst_led_1", led, 1'b1);
        check("rst_pwm_1", pwm_all, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        check("first_key_led", led, 1'b0);
        ena = 1'b0;

        // Motor B forward, 128 degrees, SPACE terminator
        send_key(K_SPACE);
        send_key(K_FWD);
        send_key(4'd1);
        send_key(4'd2);
        send_key(4'd8);
        check("pre_term_led", led, 1'b0);
        check("pre_term_pwm", pwm_all, 16'h0000);
        send_key(K_SPACE);
        run_check(2, 1'b0, 128, 128 * STEP_DIV, 1'b0);

        // Motor A backward, 87 degrees, keys strobed during the run
        send_key(4'd1);
        send_key(K_SPACE);
        send_key(K_BWD);
        send_key(4'd8);
        send_key(4'd7);
        send_key(K_ENTER);
        run_check(1, 1'b1, 87, 87 * STEP_DIV, 1'b1);

        // 400 exceeds the limit
        send_key(4'd3);
        send_key(K_SPACE);
        send_key(K_BWD);
        send_key(4'd4);
        send_key(4'd0);
        send_key(4'd0);
        send_key(K_ENTER);
        check("over_max_led", led, 1'b1);
        check("over_max_pwm", pwm_all, 16'h0000);
        @(negedge clk);
        check("over_max_pwm_later", pwm_all, 16'h0000);

        // Fourth digit aborts
        send_key(4'd4);
        send_key(K_SPACE);
        send_key(K_FWD);
        send_key(4'd7);
        send_key(4'd0);
        send_key(4'd0);
        check("three_digits_led", led, 1'b0);
        send_key(4'd0);
        check("fourth_digit_led", led, 1'b1);
        send_key(K_ENTER);
        check("after_abort_led", led, 1'b1);
        check("after_abort_pwm", pwm_all, 16'h0000);

        // Invalid motor digits and invalid key after motor
        send_key(4'd5);
        check("digit5_led", led, 1'b1);
        send_key(4'd0);
        check("digit0_led", led, 1'b1);
        send_key(4'd2);
        check("motor2_led", led, 1'b0);
        send_key(K_INV);
        check("invalid_led", led, 1'b1);
        check("invalid_pwm", pwm_all, 16'h0000);

        // Zero angle: no motion
        send_key(4'd4);
        send_key(K_SPACE);
        send_key(K_FWD);
        send_key(4'd0);
        send_key(K_ENTER);
        check("zero_angle_led", led, 1'b1);
        check("zero_angle_pwm", pwm_all, 16'h0000);
        @(negedge clk);
        check("zero_angle_pwm_later", pwm_all, 16'h0000);

        // Reset in the middle of a run on motor C
        send_key(4'd3);
        send_key(K_SPACE);
        send_key(K_FWD);
        send_key(4'd5);
        send_key(K_ENTER);
        run_check(3, 1'b0, 5, 6, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_run_reset_pwm", pwm_all, 16'h0000);
        check("mid_run_reset_led", led, 1'b1);
        rst = 1'b0;

        // Normal command after reset: motor D backward, 3 degrees
        send_key(4'd4);
        send_key(K_SPACE);
        send_key(K_BWD);
        send_key(4'd3);
        send_key(K_SPACE);
        run_check(4, 1'b1, 3, 3 * STEP_DIV, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/top_data_sm.md
# top_data_sm

Keypad command interpreter and four-channel stepper driver for the board. It consumes decoded key codes (digits, SPACE, ENTER, FORWARD, BACKWARD, INVALID) strobed by a key-valid signal and assembles commands of the form `motor SPACE direction angle terminator`. It then drives the selected motor's 4-bit full-step phase outputs for one step per degree. It sits between the keypad decoder and the motor driver pins.

## Interface
- STEP_DIV, 50000: clock cycles each phase pattern is held (one step); benches use 4.
- MAX_ANGLE, 360: largest accepted angle in degrees.
- in_Clk  in  1  system clock, all logic on rising edge.
- in_Rst  in  1  reset; synchronous, active-high.
- i_ena  in  1  key-valid strobe from decoder.
- i_data_dec  in  4  key code: 0-9 digits, 10 SPACE, 11 ENTER, 12 FORWARD, 13 BACKWARD, 14 INVALID, 15 unused.
- out_led_ini  out  1  high while idle and ready for a new command.
- out_Motor_PWM_A  out  4  phase outputs, motor 1.
- out_Motor_PWM_B  out  4  phase outputs, motor 2.
- out_Motor_PWM_C  out  4  phase outputs, motor 3.
- out_Motor_PWM_D  out  4  phase outputs, motor 4.

## Operation
- Key acceptance: i_ena is registered (ena_q, reset to 0). A key is accepted on a rising edge where i_ena=1 and ena_q=0; i_data_dec is sampled on that same edge. A level held high yields exactly one key. i_ena already high when reset releases counts as one key on the first post-reset edge.
- FSM states: IDLE, MOTOR, SEP, DIR, ANGLE, RUN.
- IDLE: out_led_ini=1. Digit 1-4 stores the motor index (1=A … 4=D) and goes to MOTOR. Any other key stays in IDLE.
- MOTOR: SPACE goes to SEP. Any other key aborts to IDLE.
- SEP: FORWARD or BACKWARD stores the direction and goes to DIR. Any other key aborts.
- DIR: a digit sets angle=digit, count=1, and goes to ANGLE. Any other key aborts.
- ANGLE:
  - A digit when count<3 sets angle=angle*10+digit and count+1. A fourth digit aborts.
  - ENTER or SPACE terminates. If angle>MAX_ANGLE, abort. If angle=0, go to IDLE with no motion. Otherwise load steps=angle, phase=0, div=0 and go to RUN.
  - INVALID, 15, FORWARD or BACKWARD aborts.
- Angle accumulator is 10 bits with no overflow possible; the 3-digit maximum is 999.
- Abort: clear motor, direction and angle; no output change.
- RUN:
  - Keys are ignored (edges are still tracked in ena_q).
  - The selected motor outputs the pattern for the current phase index; all other motors output 0000.
  - Forward sequence: 1000, 0100, 0010, 0001, repeating.
  - Backward sequence: 0001, 0010, 0100, 1000, repeating.
  - div counts 0..STEP_DIV-1. On wrap, phase = (phase+1) mod 4 and steps decrements.
  - When the last step's hold expires (steps reaches 0), all outputs return to 0000 and the FSM goes to IDLE.
- Outside RUN, all motor outputs are 0000.

## Timing
- All outputs are registered.
- Reset (any state, including mid-RUN) takes effect at the next edge: FSM=IDLE, out_led_ini=1, all motor outputs 0000, ena_q=0, all counters and stored fields 0.
- Terminator accepted at edge N: at edge N, out_led_ini is already 0 (it fell when the motor digit was accepted), and the pattern for phase 0 appears after edge N.
- Each pattern is held exactly STEP_DIV cycles, so the motion lasts angle*STEP_DIV cycles.
- The output becomes 0000 and out_led_ini=1 at the edge ending the last hold. A key strobed on that same edge is ignored; the next rising strobe is accepted.
- out_led_ini falls on the edge that accepts a valid motor digit and rises on the edge that enters IDLE (abort, zero-angle completion, RUN completion, reset).
- Minimum key spacing is 2 cycles: one cycle high, one cycle low.

## Test plan
- Reset held 2 cycles with i_ena=1 -> out_led_ini=1 and all PWM outputs 0000 during reset. After release, the first sampled digit (2) is accepted and out_led_ini=0.
- Keys 2, SPACE, FORWARD, 1, 2, 8, SPACE with STEP_DIV=4 -> out_Motor_PWM_B cycles 1000→0100→0010→0001 for 128 steps (512 cycles) and ends 0000. A, C, D stay 0000. out_led_ini returns to 1.
- Keys 1, SPACE, BACKWARD, 8, 7, ENTER -> out_Motor_PWM_A runs the sequence 0001, 0010, 0100, 1000 for 87 steps. Keys strobed during RUN have no effect.
- Keys 3, SPACE, BACKWARD, 4, 0, 0, ENTER (400 > 360) -> no motion and a return to IDLE. Keys 4, SPACE, FORWARD, 7, 0, 0, 0 -> aborts on the fourth digit.
- Keys 5 (or 0) in IDLE, or 2 followed by INVALID -> FSM in IDLE with out_led_ini=1 and outputs 0000. Keys 4, SPACE, FORWARD, 0, ENTER -> no motion.
- Reset asserted mid-RUN on motor C -> at the next edge C=0000 and out_led_ini=1. A new command then executes normally.
